uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Round-robin packet arbiter that shares the single UART transmit path among `N_REQ` byte-stream requesters. It sits between the requesters and the transmit side of `uart_ctl`, driving `din`/`din_rdy` and pacing on the transmitter's `tx_rdy`. A grant is held for a whole packet, so packets from different requesters never interleave on the line.

## Interface
- `N_REQ`, default 4: number of requesters, ≥2.
- `BUSY_TO`, default 15: clock cycles allowed for `tx_rdy` to fall after a `din_rdy` strobe, ≥1.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester byte valid.
- `req_data`  in  8*N_REQ  per-requester byte; requester i uses `[8i+7:8i]`.
- `req_last`  in  N_REQ  marks the presented byte as the last byte of its packet.
- `req_ack`  out  N_REQ  one-cycle pulse: the presented byte has been taken.
- `tx_rdy`  in  1  transmitter idle/ready, from `tx_ctl`.
- `din`  out  8  byte to the transmitter.
- `din_rdy`  out  1  one-cycle load strobe to the transmitter.
- `grant`  out  N_REQ  one-hot owner of the transmit path; 0 when idle.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
States: IDLE, LOAD, STROBE, DRAIN. Encoding: 2-bit.

- **IDLE:**
  - When `|req_valid` and `tx_rdy` are both high, pick the winner by round-robin starting at `rr_ptr`.
  - Register the winner into `gidx`, set `grant`, then go to LOAD.
- **LOAD:**
  - If `req_valid[gidx]` is high:
    - drive `req_ack[gidx]`=1 combinationally this cycle;
    - register `din`←the requester's byte, `last_r`←`req_last[gidx]`, `din_rdy`←1;
    - go to STROBE.
  - Otherwise stay in LOAD. The requester may stall mid-packet indefinitely and the grant is kept.
- **STROBE:**
  - `din_rdy` is high for exactly this cycle and is cleared on exit.
  - `to_cnt` starts at 0. Move to DRAIN when `tx_rdy`=0, or when `to_cnt`==BUSY_TO−1 (timeout).
  - Otherwise increment `to_cnt`.
  - `to_cnt` width is `$clog2(BUSY_TO+1)`.
- **DRAIN:**
  - Wait for `tx_rdy`=1.
  - Then, if `last_r`: `rr_ptr`←(`gidx`+1) mod N_REQ, `grant`←0, go to IDLE.
  - Else go to LOAD.
- **Round-robin:** search order is `rr_ptr`, `rr_ptr`+1, … with wrap. `rr_ptr` advances only at packet end, never per byte.
- **Simultaneous requests** in IDLE: exactly one wins, according to `rr_ptr`. The others wait; their `req_ack` stays 0.
- **Requests dropped:** `req_valid` of a non-granted requester may change freely and has no effect.
- **Reset mid-packet:** all state returns to IDLE and `rr_ptr`=0. A byte already strobed may still complete on the line; no ack is repeated.

## Timing
- **Reset values:** `din`=8'h00, `din_rdy`=0, `req_ack`=0, `grant`=0, `busy`=0, `rr_ptr`=0, `to_cnt`=0.
- **Cycle sequence:** request seen in IDLE at cycle t → `grant` at t+1 (LOAD) → `req_ack` at t+1 → `din`/`din_rdy` at t+2.
- **Ack ordering:** `req_ack` precedes `din_rdy` by exactly one cycle. The requester must present the next byte (or drop valid) from the cycle after the ack.
- **Back-to-back bytes:** there is a minimum of 1 cycle in LOAD plus 1 cycle in STROBE, plus DRAIN until `tx_rdy` returns.
- **Output registration:** `din_rdy` and `din` are registered; `req_ack` is combinational from state and `req_valid`.
- **Grant switch:** at most one idle cycle (IDLE) between the last DRAIN of one packet and the next grant.

## Structure
- Package `uart_pkg` holds:
  - the state typedef/localparams (IDLE=0, LOAD=1, STROBE=2, DRAIN=3);
  - the byte width constant (8).
- Sub-module `uart_rr_pick`: combinational round-robin pick of a one-hot winner and its index from a request vector and a pointer, parameterised by N_REQ.
- The state machine, timeout counter and output registers live in `uart_tx_arb`.

## Test plan
- **Single byte:** `req_valid`=4'b0010, data 8'hA5, last=1, with a `tx_rdy` model that goes low 2 cycles after the strobe and high 20 cycles later. Expect: `req_ack`=4'b0010 for one cycle; `din`=8'hA5 with a single `din_rdy` pulse; `grant` back to 0 and `busy`=0 after `tx_rdy` rises.
- **Contention and fairness:** all four requesters send 1-byte packets repeatedly. Expect grants in order 0,1,2,3,0 with no requester served twice in a row.
- **Packet lock:** requester 2 sends 3 bytes 8'h11, 8'h22, 8'h33 (last on 8'h33) while requester 0 requests throughout. Expect `din` to carry 11, 22, 33 before any byte from requester 0, and `grant` to stay 4'b0100 for all three.
- **Mid-packet stall:** requester 1 drops `req_valid` for 10 cycles after its first byte. Expect the state to stay in LOAD, `grant`=4'b0010, and no `din_rdy`. Transfer resumes when valid returns.
- **Timeout:** `tx_rdy` is held high (it never drops). Expect STROBE to exit after exactly BUSY_TO cycles, then the next byte to load.
- **Async reset mid-packet:** assert `rst`=0 during DRAIN. Expect all outputs to go to their reset values immediately. After release with requesters 3 and 0 both pending, expect requester 0 to win (`rr_ptr`=0).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side arbiter.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STROBE = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: first set request at or after i_ptr, with wrap.
module uart_rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [$clog2(N_REQ)-1:0] o_idx
);
  localparam int IW = $clog2(N_REQ);

  logic w_found;
  int   w_j;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N_REQ) w_j = w_j - N_REQ;
      if (!w_found && i_req[w_j]) begin
        w_found    = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-granular round-robin arbiter feeding a single UART transmitter.
// A grant is held from the first byte of a packet until its last byte drains.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int BUSY_TO = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ack,
  input  logic                    tx_rdy,
  output logic [BYTE_W-1:0]       din,
  output logic                    din_rdy,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy
);
  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(BUSY_TO + 1);

  state_t            r_state, w_next;
  logic [IW-1:0]     r_gidx, r_rr_ptr, w_pick_idx, w_ptr_nxt;
  logic [N_REQ-1:0]  r_grant, w_pick_gnt;
  logic [TW-1:0]     r_to_cnt;
  logic [BYTE_W-1:0] r_din;
  logic              r_din_rdy, r_last;
  logic              w_start, w_take, w_to_hit;

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx)
  );

  assign w_start   = (|req_valid) && tx_rdy;
  assign w_take    = req_valid[r_gidx];
  assign w_to_hit  = (r_to_cnt == TW'(BUSY_TO - 1));
  assign w_ptr_nxt = (r_gidx == IW'(N_REQ - 1)) ? '0 : r_gidx + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_start) w_next = ST_LOAD;
      ST_LOAD:   if (w_take) w_next = ST_STROBE;
      ST_STROBE: if (!tx_rdy || w_to_hit) w_next = ST_DRAIN;
      ST_DRAIN:  if (tx_rdy) w_next = r_last ? ST_IDLE : ST_LOAD;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ack = '0;
    if (r_state == ST_LOAD) req_ack[r_gidx] = req_valid[r_gidx];
    busy = (r_state != ST_IDLE);
  end

  // din_rdy is a single-cycle pulse on STROBE entry even if STROBE lasts longer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gidx    <= '0;
      r_grant   <= '0;
      r_rr_ptr  <= '0;
      r_to_cnt  <= '0;
      r_din     <= '0;
      r_din_rdy <= 1'b0;
      r_last    <= 1'b0;
    end else begin
      r_din_rdy <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_start) begin
          r_gidx  <= w_pick_idx;
          r_grant <= w_pick_gnt;
        end
        ST_LOAD: begin
          r_to_cnt <= '0;
          if (w_take) begin
            r_din     <= req_data[BYTE_W*r_gidx +: BYTE_W];
            r_last    <= req_last[r_gidx];
            r_din_rdy <= 1'b1;
          end
        end
        ST_STROBE: r_to_cnt <= (w_next == ST_STROBE) ? r_to_cnt + 1'b1 : '0;
        ST_DRAIN: if (tx_rdy && r_last) begin
          r_rr_ptr <= w_ptr_nxt;
          r_grant  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign din     = r_din;
  assign din_rdy = r_din_rdy;
  assign grant   = r_grant;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: requester queues, a tx_rdy model and a strobe log.
module tb_uart_tx_arb;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_last, req_ack, grant;
  logic [31:0] req_data;
  logic        tx_rdy, din_rdy, busy;
  logic [7:0]  din;

  int   errors = 0;
  int   checks = 0;
  bit   tx_mode;
  int   tx_cnt = 0;
  int   cyc = 0;
  logic [3:0] hold;
  logic [8:0] rq [4][$];

  typedef struct {
    logic [3:0] g;
    logic [7:0] d;
    int         c;
  } ent_t;
  ent_t log_q[$];

  uart_tx_arb #(.N_REQ(4), .BUSY_TO(15)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ack(req_ack), .tx_rdy(tx_rdy), .din(din),
    .din_rdy(din_rdy), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  // Transmitter: busy from 2 cycles after the strobe for 20 cycles; mode 1 never busy.
  always @(posedge clk) begin
    if (din_rdy && !tx_mode) tx_cnt <= 22;
    else if (tx_cnt > 0)     tx_cnt <= tx_cnt - 1;
  end
  assign tx_rdy = tx_mode || !(tx_cnt >= 1 && tx_cnt <= 20);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (din_rdy) log_q.push_back('{grant, din, cyc});
  end

  // Requesters pop their head byte after an ack and present the next one.
  initial begin
    logic [3:0] a;
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge clk); a = req_ack;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (a[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0 && !hold[i]) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = rq[i][0][7:0];
          req_last[i] = rq[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  task automatic wait_log(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (log_q.size() >= n && !busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (din_rdy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (din !== 8'h00) begin errors++; $display("FAIL reset_din: got %h exp 00", din); end
    checks++; if (din_rdy !== 1'b0) begin errors++; $display("FAIL reset_din_rdy: got %b exp 0", din_rdy); end
    checks++; if (req_ack !== 4'b0) begin errors++; $display("FAIL reset_ack: got %b exp 0000", req_ack); end
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant: got %b exp 0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    rst = 1'b1;
  endtask

  task automatic test_single_byte;
    bit ok;
    log_q.delete();
    @(negedge clk); rq[1].push_back({1'b1, 8'hA5});
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b exp 0", busy); end
    @(negedge clk);
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL single_grant: got %b exp 0010", grant); end
    checks++; if (req_ack !== 4'b0010) begin errors++; $display("FAIL single_ack: got %b exp 0010", req_ack); end
    checks++; if (din_rdy !== 1'b0) begin errors++; $display("FAIL single_early_strobe: got %b exp 0", din_rdy); end
    @(negedge clk);
    checks++; if (din_rdy !== 1'b1) begin errors++; $display("FAIL single_strobe: got %b exp 1", din_rdy); end
    checks++; if (din !== 8'hA5) begin errors++; $display("FAIL single_din: got %h exp a5", din); end
    checks++; if (req_ack !== 4'b0) begin errors++; $display("FAIL single_ack_once: got %b exp 0000", req_ack); end
    wait_log(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got busy=%b exp idle", busy); end
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL single_grant_release: got %b exp 0000", grant); end
    checks++; if (log_q.size() !== 1) begin errors++; $display("FAIL single_pulses: got %0d exp 1", log_q.size()); end
  endtask

  task automatic test_fairness;
    bit ok;
    logic [7:0] ed;
    logic [3:0] eg;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    log_q.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) rq[i].push_back({1'b1, 8'(8'h80 + 16*i + r)});
    wait_log(8, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fair_timeout: got %0d bytes exp 8", log_q.size()); end
    for (int k = 0; k < 8 && k < log_q.size(); k++) begin
      eg = 4'b0001 << (k % 4);
      ed = 8'(8'h80 + 16*(k % 4) + k/4);
      checks++; if (log_q[k].g !== eg) begin errors++; $display("FAIL fair_grant[%0d]: got %b exp %b", k, log_q[k].g, eg); end
      checks++; if (log_q[k].d !== ed) begin errors++; $display("FAIL fair_din[%0d]: got %h exp %h", k, log_q[k].d, ed); end
    end
  endtask

  task automatic test_packet_lock;
    bit ok;
    logic [7:0] ed [4];
    logic [3:0] eg [4];
    ed = '{8'h11, 8'h22, 8'h33, 8'hC0};
    eg = '{4'b0100, 4'b0100, 4'b0100, 4'b0001};
    log_q.delete();
    @(negedge clk);
    rq[2].push_back({1'b0, 8'h11}); rq[2].push_back({1'b0, 8'h22}); rq[2].push_back({1'b1, 8'h33});
    wait_strobe(ok);
    rq[0].push_back({1'b1, 8'hC0});
    checks++; if (!ok) begin errors++; $display("FAIL lock_start: got no strobe exp strobe"); end
    wait_log(4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL lock_timeout: got %0d bytes exp 4", log_q.size()); end
    for (int k = 0; k < 4 && k < log_q.size(); k++) begin
      checks++; if (log_q[k].g !== eg[k]) begin errors++; $display("FAIL lock_grant[%0d]: got %b exp %b", k, log_q[k].g, eg[k]); end
      checks++; if (log_q[k].d !== ed[k]) begin errors++; $display("FAIL lock_din[%0d]: got %h exp %h", k, log_q[k].d, ed[k]); end
    end
  endtask

  task automatic test_stall;
    bit ok;
    log_q.delete();
    @(negedge clk);
    rq[1].push_back({1'b0, 8'h51}); rq[1].push_back({1'b1, 8'h52});
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (log_q.size() >= 1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL stall_first: got no byte exp 51"); end
    hold[1] = 1'b1;
    rq[3].push_back({1'b1, 8'h3A});
    repeat (40) @(negedge clk);
    checks++; if (dut.r_state !== ST_LOAD) begin errors++; $display("FAIL stall_state: got %0d exp %0d", dut.r_state, ST_LOAD); end
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL stall_grant: got %b exp 0010", grant); end
    checks++; if (log_q.size() !== 1) begin errors++; $display("FAIL stall_strobe: got %0d bytes exp 1", log_q.size()); end
    hold[1] = 1'b0;
    wait_log(3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: got %0d bytes exp 3", log_q.size()); end
    if (log_q.size() >= 3) begin
      checks++; if (log_q[1].d !== 8'h52 || log_q[1].g !== 4'b0010) begin errors++; $display("FAIL stall_resume: got %h/%b exp 52/0010", log_q[1].d, log_q[1].g); end
      checks++; if (log_q[2].d !== 8'h3A || log_q[2].g !== 4'b1000) begin errors++; $display("FAIL stall_next: got %h/%b exp 3a/1000", log_q[2].d, log_q[2].g); end
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int n;
    tx_mode = 1'b1;
    log_q.delete();
    @(negedge clk);
    rq[0].push_back({1'b0, 8'h71}); rq[0].push_back({1'b1, 8'h72});
    wait_strobe(ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_start: got no strobe exp strobe"); end
    n = 0;
    while (dut.r_state == ST_STROBE && n < 100) begin n++; @(negedge clk); end
    checks++; if (n !== 15) begin errors++; $display("FAIL to_strobe_len: got %0d exp 15", n); end
    wait_log(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_timeout: got %0d bytes exp 2", log_q.size()); end
    if (log_q.size() >= 2) begin
      checks++; if (log_q[1].c - log_q[0].c !== 17) begin errors++; $display("FAIL to_spacing: got %0d exp 17", log_q[1].c - log_q[0].c); end
      checks++; if (log_q[1].d !== 8'h72) begin errors++; $display("FAIL to_din2: got %h exp 72", log_q[1].d); end
    end
    tx_mode = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit ok;
    log_q.delete();
    @(negedge clk); rq[1].push_back({1'b1, 8'h99});
    wait_strobe(ok);
    repeat (5) @(negedge clk);
    checks++; if (dut.r_state !== ST_DRAIN) begin errors++; $display("FAIL rmid_drain: got %0d exp %0d", dut.r_state, ST_DRAIN); end
    rq[3].push_back({1'b1, 8'h33}); rq[0].push_back({1'b1, 8'h0A});
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL rmid_grant: got %b exp 0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b exp 0", busy); end
    checks++; if (din !== 8'h00 || din_rdy !== 1'b0) begin errors++; $display("FAIL rmid_din: got %h/%b exp 00/0", din, din_rdy); end
    checks++; if (req_ack !== 4'b0) begin errors++; $display("FAIL rmid_ack: got %b exp 0000", req_ack); end
    @(negedge clk); rst = 1'b1;
    wait_log(3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_timeout: got %0d bytes exp 3", log_q.size()); end
    if (log_q.size() >= 3) begin
      checks++; if (log_q[1].g !== 4'b0001 || log_q[1].d !== 8'h0A) begin errors++; $display("FAIL rmid_winner: got %b/%h exp 0001/0a", log_q[1].g, log_q[1].d); end
      checks++; if (log_q[2].g !== 4'b1000 || log_q[2].d !== 8'h33) begin errors++; $display("FAIL rmid_second: got %b/%h exp 1000/33", log_q[2].g, log_q[2].d); end
    end
  endtask

  initial begin
    rst = 1'b0; tx_mode = 1'b0; hold = '0;
    test_reset;
    test_single_byte;
    test_fairness;
    test_packet_lock;
    test_stall;
    test_timeout;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
